regfile_multiport: RTL
======================

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the register width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the register count to NREGS = 2**ADDR_WIDTH.
REQ-003 Parameter NUM_READ, default 3, SHALL set the number of read ports.
REQ-004 Parameter HARDWIRE_ZERO, default 1; when 1, register 0 SHALL always read as zero and ignore writes.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-006 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-007 clear_req  in  1  SHALL request a full register-file clear sequence.
REQ-008 ready  out  1  SHALL indicate that the file accepts writes and returns valid read data.
REQ-009 we0 / waddr0 / wdata0  in  1 / ADDR_WIDTH / DATA_WIDTH  SHALL form write port 0.
REQ-010 we1 / waddr1 / wdata1  in  1 / ADDR_WIDTH / DATA_WIDTH  SHALL form write port 1.
REQ-011 raddr  in  NUM_READ*ADDR_WIDTH  SHALL carry the read addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 rdata  out  NUM_READ*DATA_WIDTH  SHALL carry the read data; port i uses bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-013 The FSM SHALL have two states, CLEAR and READY; ready SHALL be 1 only in READY.
REQ-014 In CLEAR, a clear counter SHALL zero one register per cycle, index 0 up to NREGS-1, with no skipped or repeated index.
REQ-015 On the cycle that clears index NREGS-1, the FSM SHALL go to READY, so a full clear takes exactly NREGS cycles.
REQ-016 clear_req sampled high in READY SHALL move the FSM to CLEAR with the counter at 0; ready SHALL go low the next cycle.
REQ-017 clear_req in CLEAR SHALL be ignored; the sequence SHALL NOT restart.
REQ-018 In CLEAR, we0 and we1 SHALL be ignored, and every rdata lane SHALL read 0.
REQ-019 In READY, a write with weN=1 SHALL update register waddrN at the clock edge.
REQ-020 If we0 and we1 are both high with waddr0 == waddr1, port 1's data SHALL be stored.
REQ-021 Reads SHALL be combinational: rdata lane i = register[raddr lane i].
REQ-022 Write-to-read bypass: in READY, if a read address matches an active write address in the same cycle, the lane SHALL return that write's data.
REQ-023 If the read address matches both active write ports, the bypass SHALL return wdata1.
REQ-024 With HARDWIRE_ZERO=1, reads of address 0 SHALL return 0, including bypass; writes to address 0 SHALL have no effect.
REQ-025 With HARDWIRE_ZERO=0, register 0 SHALL behave as a normal register.
REQ-026 Read ports SHALL be independent; any number of lanes may address the same register in one cycle.

Reset
REQ-027 rst high SHALL force state CLEAR with the counter at 0, and ready SHALL be 0 on the next cycle.
REQ-028 After rst is released, ready SHALL rise exactly NREGS cycles later, with all registers at 0.
REQ-029 rst asserted during a clear sequence SHALL restart the counter at 0.
REQ-030 rst SHALL take priority over clear_req and writes.

Verification
REQ-031 Release rst, hold we0=1 waddr0=3 wdata0=0xAA during clear -> ready=0 for exactly 32 cycles, rdata=0, then x3 reads 0 (write dropped).
REQ-032 In READY, we0=1 waddr0=5 wdata0=0x1234, raddr lane0=5 in the same cycle -> lane0=0x1234 combinationally and x5=0x1234 after the edge.
REQ-033 Drive we0/we1 both to address 7 with 0x11 and 0x22, lane1 reading 7 -> lane1=0x22 in-cycle, x7=0x22 afterwards.
REQ-034 With HARDWIRE_ZERO=1, we1=1 waddr1=0 wdata1=0xFFFFFFFF, all lanes reading 0 -> every lane 0, before and after the edge.
REQ-035 Fill x1..x31 with nonzero values, pulse clear_req -> ready low 32 cycles; pulse clear_req again at cycle 10 -> no extension; afterwards all registers 0.
REQ-036 Assert rst at clear cycle 20 for one cycle -> ready rises exactly 32 cycles after rst deasserts.

Source files
------------

// File: rtl/regfile_multiport.sv
// regfile_multiport: two-write, multi-read register file with sequential clear and write-to-read bypass
module regfile_multiport #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int NUM_READ      = 3,
  parameter int HARDWIRE_ZERO = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_req,
  output logic                             ready,
  input  logic                             we0,
  input  logic [ADDR_WIDTH-1:0]            waddr0,
  input  logic [DATA_WIDTH-1:0]            wdata0,
  input  logic                             we1,
  input  logic [ADDR_WIDTH-1:0]            waddr1,
  input  logic [DATA_WIDTH-1:0]            wdata1,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rdata
);
  localparam int NREGS = 2**ADDR_WIDTH;
  typedef enum logic {CLEAR, READY} state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_regs [NREGS];
  logic                  w_we0, w_we1;
  assign ready = r_state == READY;
  // Writes are live only in READY, never under reset, and never to a hardwired-zero register 0.
  assign w_we0 = ready && !rst && we0 && !(HARDWIRE_ZERO != 0 && waddr0 == '0);
  assign w_we1 = ready && !rst && we1 && !(HARDWIRE_ZERO != 0 && waddr1 == '0);
  // Next state: reset forces CLEAR; clear_req only counts in READY; CLEAR exits after the last index.
  always_comb
    w_next = rst ? CLEAR : ready ? (clear_req ? CLEAR : READY) : (&r_cnt ? READY : CLEAR);
  // State register and clear counter; the counter idles at 0 so every clear starts from index 0.
  always_ff @(posedge clk) begin
    r_state <= w_next;
    r_cnt   <= (rst || ready) ? '0 : r_cnt + 1'b1;
  end
  // Storage: zero one entry per clear cycle, otherwise apply writes with port 1 winning collisions.
  always_ff @(posedge clk) begin
    if (!rst && !ready) r_regs[r_cnt] <= '0;
    else begin
      if (w_we0) r_regs[waddr0] <= wdata0;
      if (w_we1) r_regs[waddr1] <= wdata1;
    end
  end
  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_a;
    assign w_a = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] =
      (!ready || (HARDWIRE_ZERO != 0 && w_a == '0)) ? '0 :
      (w_we1 && w_a == waddr1) ? wdata1 :
      (w_we0 && w_a == waddr0) ? wdata0 : r_regs[w_a];
  end
endmodule
